zero_count_seq: RTL and testbench
=================================

# zero_count_seq

Multi-cycle count-leading-zeros / count-trailing-zeros unit for the integer execute stage. It scans an XLEN-bit operand one SLICE-bit slice per cycle through a single narrow zero-count cell. It returns the count over a valid/ready response channel. Area is traded for latency, so one small counter serves clz and ctz for any XLEN.

## Interface
- XLEN, 32: operand width; must be a multiple of SLICE.
- SLICE, 8: bits examined per cycle; power of two, at least 2.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  abort any operation; synchronous.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept a request.
- req_data_i  in  XLEN  operand.
- req_mode_i  in  1  0 = clz (count from MSB), 1 = ctz (count from LSB).
- resp_valid_o  out  1  result present.
- resp_ready_i  in  1  consumer takes the result.
- resp_count_o  out  $clog2(XLEN+1)  zero count, 0..XLEN.
- resp_zero_o  out  1  operand was all zeros (count == XLEN).

## Operation
- N = XLEN/SLICE slices. Slice k for clz is bits [XLEN-1-k*SLICE -: SLICE]; for ctz it is bits [k*SLICE +: SLICE].
- FSM states:
  - IDLE: req_ready_o = 1. On req_valid_i & ~flush_i, latch operand and mode, clear slice index k to 0, and go to SCAN.
  - SCAN: examine slice k.
    - If the slice is nonzero: count = k*SLICE + in-slice count, then go to DONE.
    - Else if k == N-1: count = XLEN, zero = 1, then go to DONE.
    - Else: k++ and stay in SCAN.
  - DONE: resp_valid_o = 1, and count and zero are held stable. On resp_ready_i, go to IDLE.
- In-slice count: zeros counted from the slice MSB for clz and from the slice LSB for ctz, width $clog2(SLICE).
- Count arithmetic is performed at $clog2(XLEN+1) bits with no overflow; the maximum is XLEN.
- req_ready_o is high only in IDLE. There is no accept in DONE, even if resp_ready_i is high.
- flush_i from any state: go to IDLE on the next edge and discard any latched or pending result. In IDLE, flush_i blocks acceptance that cycle; flush wins over req_valid_i.

## Timing
- Reset values: state IDLE, req_ready_o = 1, resp_valid_o = 0, resp_count_o = 0, resp_zero_o = 0, k = 0.
- Accept edge E0. Slice k is examined in cycle E0+k+1. resp_valid_o rises in the cycle after the deciding slice.
- Latency from accept edge to resp_valid_o = (slices examined) + 1, giving 2..N+1 cycles.
- Response held indefinitely under backpressure. Outputs change only when leaving DONE.
- Throughput: one request per (latency + 1) cycles at best, because of the DONE-to-IDLE return.
- Reset asserted mid-operation: immediately return to the reset values. No response is emitted.

## Configuration
- ZERO_COUNT_SEQ_ZERO_SKIP_EN
  - Defined: an all-zero operand is detected at acceptance (reduction-OR of req_data_i). The FSM goes straight to DONE with count = XLEN and zero = 1. Latency is 1.
  - Undefined: an all-zero operand scans all N slices. Latency is N+1.
- Results are identical either way; only latency differs.

## Structure
- Shared package zero_count_pkg holds:
  - the mode enum (ZC_CLZ = 0, ZC_CTZ = 1);
  - the FSM state enum (IDLE, SCAN, DONE);
  - the count-width localparam function $clog2(XLEN+1).
- Sub-module: zero_count_slice, the combinational SLICE-bit zero counter with a slice-nonzero flag.
- The controller presents each slice to zero_count_slice in LSB-first order: the slice is bit-reversed for clz and passed unchanged for ctz.

## Test plan
- clz 0x0001_0000 (XLEN = 32, SLICE = 8) -> resp_count_o = 15, resp_zero_o = 0, resp_valid_o 3 cycles after accept.
- ctz 0x8000_0000 -> count 31, all 4 slices examined, latency 5. Also clz 0x8000_0000 -> count 0, latency 2.
- Operand 0x0000_0000, both modes -> count 32, zero = 1. Latency is 1 with ZERO_COUNT_SEQ_ZERO_SKIP_EN defined, 5 without.
- clz 0x00F0_0000 with resp_ready_i held low 4 cycles -> count 8 held stable, req_ready_o = 0 throughout, and a new req_valid_i is ignored until handshake.
- ctz 0x0100_0000 with flush_i pulsed in the second SCAN cycle -> IDLE next cycle, no resp_valid_o, req_ready_o = 1. A following ctz 0x0000_0004 returns 2.
- rst_i asserted mid-SCAN -> all outputs at reset values asynchronously. A post-reset clz 0x0000_0001 returns 31.

Source files
------------

// File: rtl/zero_count_seq_pkg.sv
// rtl/zero_count_seq_pkg.sv - shared types and sizing helpers for the sequential zero counter
//
// Package zero_count_pkg:
//   zc_mode_e      : ZC_CLZ (count from MSB) / ZC_CTZ (count from LSB)
//   zc_state_e     : controller states IDLE / SCAN / DONE
//   zc_count_width : bits needed to hold a count of 0..xlen
package zero_count_pkg;

  typedef enum logic {
    ZC_CLZ = 1'b0,
    ZC_CTZ = 1'b1
  } zc_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } zc_state_e;

  function automatic int zc_count_width(input int xlen);
    return $clog2(xlen + 1);
  endfunction

endpackage

// File: rtl/zero_count_seq_if.sv
// rtl/zero_count_seq_if.sv - request/response channel bundle for the sequential zero counter
//
// Parameter XLEN: operand width.
// Signals:
//   req_valid_i / req_ready_o : request handshake
//   req_data_i, req_mode_i    : operand and mode (0 = clz, 1 = ctz)
//   resp_valid_o / resp_ready_i : response handshake
//   resp_count_o, resp_zero_o : zero count (0..XLEN) and all-zero flag
// Modports: master drives requests and takes responses, slave is the unit.
interface zero_count_seq_if #(
  parameter int XLEN = 32
);
  import zero_count_pkg::*;

  localparam int CW = zc_count_width(XLEN);

  logic            req_valid_i;
  logic            req_ready_o;
  logic [XLEN-1:0] req_data_i;
  logic            req_mode_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [CW-1:0]   resp_count_o;
  logic            resp_zero_o;

  modport master (
    output req_valid_i, req_data_i, req_mode_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_count_o, resp_zero_o
  );

  modport slave (
    input  req_valid_i, req_data_i, req_mode_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_count_o, resp_zero_o
  );

endinterface

// File: rtl/zero_count_seq_slice.sv
// rtl/zero_count_seq_slice.sv - combinational SLICE-bit trailing-zero counter cell
//
// Module zero_count_slice.
// Ports:
//   data    : slice presented LSB-first
//   count   : number of zeros below the lowest set bit (don't-care when data == 0)
//   nonzero : slice contains at least one set bit
module zero_count_slice #(
  parameter int SLICE = 8,
  localparam int SW = $clog2(SLICE)
) (
  input  logic [SLICE-1:0] data,
  output logic [SW-1:0]    count,
  output logic             nonzero
);

  // Scan MSB to LSB so the last hit, i.e. the lowest set bit, wins.
  always_comb begin
    count = '0;
    for (int i = SLICE - 1; i >= 0; i--) begin
      if (data[i]) count = SW'(i);
    end
  end

  assign nonzero = |data;

endmodule

// File: rtl/zero_count_seq.sv
// rtl/zero_count_seq.sv - multi-cycle clz/ctz unit scanning one slice per cycle
//
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   flush_i : synchronous abort, returns to IDLE and drops any result
//   bus     : zero_count_seq_if.slave request/response channel
// Parameters: XLEN (multiple of SLICE), SLICE (power of two, >= 2).
// Build option ZERO_COUNT_SEQ_ZERO_SKIP_EN: an all-zero operand is resolved
// at acceptance and goes straight to DONE instead of scanning every slice.
module zero_count_seq
  import zero_count_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SLICE = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  zero_count_seq_if.slave bus
);

  localparam int N  = XLEN / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(SLICE);
  localparam int CW = zc_count_width(XLEN);

  zc_state_e               state_q, state_d;
  logic [KW-1:0]           k_q, k_d, k_sel;
  logic [N-1:0][SLICE-1:0] op_q, op_d;
  zc_mode_e                mode_q, mode_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    zero_q, zero_d;
  logic [SLICE-1:0]        slice_raw, slice_lsb;
  logic [SW-1:0]           in_cnt;
  logic                    slice_nz;

  // clz walks slices from the top and bit-reverses each one so the shared
  // cell always counts from its LSB.
  always_comb begin
    k_sel     = (mode_q == ZC_CLZ) ? KW'(N - 1) - k_q : k_q;
    slice_raw = op_q[k_sel];
    slice_lsb = '0;
    for (int j = 0; j < SLICE; j++) begin
      slice_lsb[j] = (mode_q == ZC_CLZ) ? slice_raw[SLICE-1-j] : slice_raw[j];
    end
  end

  zero_count_slice #(.SLICE(SLICE)) u_slice (
    .data    (slice_lsb),
    .count   (in_cnt),
    .nonzero (slice_nz)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    op_d    = op_q;
    mode_d  = mode_q;
    count_d = count_q;
    zero_d  = zero_q;
    if (flush_i) begin
      state_d = IDLE;
      k_d     = '0;
      count_d = '0;
      zero_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid_i) begin
            op_d    = bus.req_data_i;
            mode_d  = zc_mode_e'(bus.req_mode_i);
            k_d     = '0;
            state_d = SCAN;
`ifdef ZERO_COUNT_SEQ_ZERO_SKIP_EN
            if (bus.req_data_i == '0) begin
              state_d = DONE;
              count_d = CW'(XLEN);
              zero_d  = 1'b1;
            end
`endif
          end
        end
        SCAN: begin
          if (slice_nz) begin
            count_d = CW'(int'(k_q) * SLICE + int'(in_cnt));
            zero_d  = 1'b0;
            state_d = DONE;
          end else if (int'(k_q) == N - 1) begin
            count_d = CW'(XLEN);
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.resp_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      op_q    <= '0;
      mode_q  <= ZC_CLZ;
      count_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.req_ready_o  = (state_q == IDLE);
  assign bus.resp_valid_o = (state_q == DONE);
  assign bus.resp_count_o = count_q;
  assign bus.resp_zero_o  = zero_q;

endmodule

// File: tb/tb_zero_count_seq.sv
// tb/tb_zero_count_seq.sv - scoreboard bench for zero_count_seq
module tb_zero_count_seq;
  import zero_count_pkg::*;

  localparam int XLEN = 32;
`ifdef ZERO_COUNT_SEQ_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 5;
`endif

  typedef struct {
    int    count;
    bit    zero;
    int    lat;
    string name;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    bit          m;
    int          cnt;
    bit          z;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  zero_count_seq_if #(.XLEN(XLEN)) bus ();

  zero_count_seq #(.XLEN(XLEN), .SLICE(8)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  // Monitor: latency counted in negedges from the accepting negedge to the
  // first negedge that sees resp_valid.
  int   neg_cnt = 0;
  int   acc_neg = 0;
  bit   prev_valid = 1'b0;
  bit   have_cur = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    neg_cnt++;
    if (bus.resp_valid_o) begin
      if (!prev_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          have_cur = 1'b0;
          $display("FAIL unexpected_resp got count=%0d expected no response", bus.resp_count_o);
        end else begin
          cur = q.pop_front();
          have_cur = 1'b1;
          chk({cur.name, "_count"}, bus.resp_count_o, cur.count);
          chk({cur.name, "_zero"}, bus.resp_zero_o, cur.zero);
          chk({cur.name, "_latency"}, neg_cnt - acc_neg, cur.lat);
        end
      end else if (have_cur) begin
        chk({cur.name, "_hold_count"}, bus.resp_count_o, cur.count);
        chk({cur.name, "_hold_zero"}, bus.resp_zero_o, cur.zero);
        chk({cur.name, "_hold_req_ready"}, bus.req_ready_o, 0);
      end
    end
    if (bus.req_valid_i && bus.req_ready_o && !flush && !rst) acc_neg = neg_cnt;
    prev_valid = bus.resp_valid_o;
  end

  task automatic send(input logic [31:0] d, input bit m, input int cnt, input bit z,
                      input int lat, input string name, input bit push);
    int n;
    if (push) q.push_back('{cnt, z, lat, name});
    bus.req_data_i  = d;
    bus.req_mode_i  = m;
    bus.req_valid_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.req_ready_o && !flush) && n < 200);
    if (n >= 200) fail_now({name, "_accept"});
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready_o && n < 100);
    if (n >= 100) fail_now({name, "_idle"});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  vec_t vecs[9];
  int   n;

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.req_data_i   = '0;
    bus.req_mode_i   = 1'b0;
    bus.resp_ready_i = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready_o, 1);
    chk("rst_resp_valid", bus.resp_valid_o, 0);
    chk("rst_resp_count", bus.resp_count_o, 0);
    chk("rst_resp_zero", bus.resp_zero_o, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    vecs[0] = '{32'h0001_0000, 1'b0, 15, 1'b0, 3};
    vecs[1] = '{32'h8000_0000, 1'b1, 31, 1'b0, 5};
    vecs[2] = '{32'h8000_0000, 1'b0, 0, 1'b0, 2};
    vecs[3] = '{32'h0000_0000, 1'b0, 32, 1'b1, ZLAT};
    vecs[4] = '{32'h0000_0000, 1'b1, 32, 1'b1, ZLAT};
    vecs[5] = '{32'h0000_0001, 1'b1, 0, 1'b0, 2};
    vecs[6] = '{32'hFFFF_FFFF, 1'b0, 0, 1'b0, 2};
    vecs[7] = '{32'h0000_0100, 1'b1, 8, 1'b0, 3};
    vecs[8] = '{32'h0000_0003, 1'b0, 30, 1'b0, 5};
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].d, vecs[i].m, vecs[i].cnt, vecs[i].z, vecs[i].lat, $sformatf("v%0d", i), 1'b1);
      wait_idle($sformatf("v%0d", i));
    end

    // Backpressure: second request waits through a held DONE.
    bus.resp_ready_i = 1'b0;
    send(32'h00F0_0000, 1'b0, 8, 1'b0, 3, "bp_a", 1'b1);
    fork
      send(32'h0000_0010, 1'b1, 4, 1'b0, 2, "bp_b", 1'b1);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.resp_valid_o && n < 50);
        if (n >= 50) fail_now("bp_a_valid");
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 bus.resp_ready_i = 1'b1;
      end
    join
    wait_idle("bp_b");

    // Flush in the second SCAN cycle drops the request.
    send(32'h0100_0000, 1'b1, 0, 1'b0, 0, "fl", 1'b0);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_req_ready", bus.req_ready_o, 1);
    chk("flush_resp_valid", bus.resp_valid_o, 0);
    repeat (6) @(posedge clk);
    #1;
    send(32'h0000_0004, 1'b1, 2, 1'b0, 2, "post_flush", 1'b1);
    wait_idle("post_flush");

    // Asynchronous reset in the middle of a scan.
    send(32'h0000_0100, 1'b0, 0, 1'b0, 0, "rs", 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_req_ready", bus.req_ready_o, 1);
    chk("midrst_resp_valid", bus.resp_valid_o, 0);
    chk("midrst_resp_count", bus.resp_count_o, 0);
    chk("midrst_resp_zero", bus.resp_zero_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(32'h0000_0001, 1'b0, 31, 1'b0, 5, "post_rst", 1'b1);
    wait_idle("post_rst");

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
